// File: rtl/imem_fetch_if.sv
// Instruction stream handshake between imem_fetch and its consumer.
// The master drives valid/data/pc; the slave drives ready.
interface imem_fetch_if #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 6
);
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr_data;
    logic [PC_W-1:0]  instr_pc;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/imem_fetch.sv
// Snapshots the flattened IMEM on start and streams it out in program order.
// Optional halt detection is enabled by defining IMEM_FETCH_HALT_DETECT_EN.
module imem_fetch #(
    parameter int               DEPTH     = 64,
    parameter int               WIDTH     = 16,
    parameter int               PC_W      = 6,
    parameter logic [WIDTH-1:0] HALT_WORD = 16'hF000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DEPTH*WIDTH-1:0] imem_flat,
    input  logic                   start,
    input  logic [PC_W-1:0]        base_pc,
    input  logic [PC_W:0]          length,
    input  logic                   abort,
    imem_fetch_if.master           ifc,
    output logic                   busy,
    output logic                   done,
    output logic                   halted
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_e;

    localparam logic [PC_W-1:0] LAST = PC_W'(DEPTH - 1);
    localparam logic [PC_W:0]   FULL = (PC_W+1)'(DEPTH);
    localparam logic [PC_W:0]   ONE  = (PC_W+1)'(1);

    state_e                 state_q, state_d;
    logic [DEPTH*WIDTH-1:0] snap_q, snap_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [PC_W:0]          rem_q, rem_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   hs;
    logic                   halt_hit;

    // Program address a lives in slot DEPTH-1-a (oldest shifted-in word).
    function automatic logic [WIDTH-1:0] word_at(
        input logic [DEPTH*WIDTH-1:0] img,
        input logic [PC_W-1:0]        a
    );
        logic [PC_W-1:0] s;
        s = LAST - a;
        return img[int'(s)*WIDTH +: WIDTH];
    endfunction

    assign hs = valid_q & ifc.instr_ready;

`ifdef IMEM_FETCH_HALT_DETECT_EN
    assign halt_hit = (data_q == HALT_WORD);
`else
    logic unused_halt_word;
    assign unused_halt_word = ^HALT_WORD;
    assign halt_hit         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        pc_d     = pc_q;
        rem_d    = rem_q;
        data_d   = data_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d   = imem_flat;
                    pc_d     = base_pc;
                    rem_d    = (length == '0) ? FULL : length;
                    data_d   = word_at(imem_flat, base_pc);
                    valid_d  = 1'b1;
                    halted_d = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (hs) begin
                    if (rem_q == ONE || halt_hit) begin
                        valid_d  = 1'b0;
                        halted_d = halt_hit;
                        state_d  = DONE;
                    end else begin
                        pc_d   = pc_q + PC_W'(1);
                        data_d = word_at(snap_q, pc_d);
                        rem_d  = rem_q - ONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            pc_q     <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            pc_q     <= pc_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign ifc.instr_valid = valid_q;
    assign ifc.instr_data  = data_q;
    assign ifc.instr_pc    = pc_q;
    assign busy            = (state_q == ISSUE);
    assign done            = (state_q == DONE);
    assign halted          = halted_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized bench for imem_fetch against a program-order word-list model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_imem_fetch;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] imem_flat;
    logic          start;
    logic [5:0]    base_pc;
    logic [6:0]    length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          halted;

    logic [15:0]   img [64];
    int            n_tests = 0;
    int            n_fail  = 0;

    imem_fetch_if #(.WIDTH(16), .PC_W(6)) ifc ();

    imem_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_flat (imem_flat),
        .start     (start),
        .base_pc   (base_pc),
        .length    (length),
        .abort     (abort),
        .ifc       (ifc),
        .busy      (busy),
        .done      (done),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] pack_img();
        logic [1023:0] v;
        for (int s = 0; s < 64; s++) v[s*16 +: 16] = img[s];
        return v;
    endfunction

    task automatic fill_rand();
        for (int s = 0; s < 64; s++) img[s] = 16'($urandom);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_valid"}, ifc.instr_valid, 0);
        chk({pfx, "_data"}, ifc.instr_data, 0);
        chk({pfx, "_pc"}, ifc.instr_pc, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_halted"}, halted, 0);
    endtask

    // Model: the run is the list of words at program addresses base, base+1..
    // (mod 64) read from the image as it stood at start, cut at a halt word.
    task automatic do_run(input int base, input int len, input int rdy_pct,
                          input int stall_at, input int abort_at,
                          input int rst_at);
        logic [15:0] exp_w[$];
        logic [15:0] w;
        int          n, k, cyc, stall;
        bit          hit, hs, ab;
        n   = (len == 0) ? 64 : len;
        hit = 0;
        for (int i = 0; i < n && !hit; i++) begin
            w = img[63 - ((base + i) % 64)];
            exp_w.push_back(w);
`ifdef IMEM_FETCH_HALT_DETECT_EN
            if (w == 16'hF000) hit = 1;
`endif
        end
        imem_flat = pack_img();
        @(negedge clk);
        chk("idle_valid", ifc.instr_valid, 0);
        chk("idle_busy", busy, 0);
        start   = 1'b1;
        base_pc = 6'(base);
        length  = 7'(len);
        abort   = 1'($urandom_range(1));
        k = 0; cyc = 0; stall = 0; hs = 0; ab = 0;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            ifc.instr_ready = 1'b0;
            if (hs) k++;
            if (ab) begin
                chk("abort_valid", ifc.instr_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                @(negedge clk);
                chk("abort_nodone", done, 0);
                break;
            end
            if (k == exp_w.size()) begin
                chk("end_done", done, 1);
                chk("end_valid", ifc.instr_valid, 0);
                chk("end_busy", busy, 0);
                chk("end_halted", halted, 32'(hit));
                @(negedge clk);
                chk("done_once", done, 0);
                chk("idle_busy2", busy, 0);
                chk("halted_hold", halted, 32'(hit));
                break;
            end
            if (cyc++ > 1000) begin
                chk("timeout", k, exp_w.size());
                break;
            end
            chk("valid", ifc.instr_valid, 1);
            chk("data", ifc.instr_data, exp_w[k]);
            chk("pc", ifc.instr_pc, (base + k) % 64);
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            chk("halted_mid", halted, 0);
            if (k == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("rst_mid");
                @(negedge clk);
                chk("rst_nodone", done, 0);
                rst_n = 1'b1;
                break;
            end
            for (int j = 0; j < 32; j++) imem_flat[j*32 +: 32] = $urandom;
            if ($urandom_range(9) == 0) begin
                start   = 1'b1;
                base_pc = 6'($urandom);
                length  = 7'($urandom);
            end
            ab    = (k == abort_at);
            abort = ab;
            if (k == stall_at && stall < 3) begin
                stall++;
                ifc.instr_ready = 1'b0;
            end else begin
                ifc.instr_ready = ($urandom_range(99) < rdy_pct);
            end
            hs = ifc.instr_ready && !ab;
        end
        start = 1'b0;
        abort = 1'b0;
        ifc.instr_ready = 1'b0;
    endtask

    initial begin
        int len, n, ab_at, rs_at;
        rst_n = 1'b0;
        start = 1'b0;
        base_pc = '0;
        length = '0;
        abort = 1'b0;
        imem_flat = '0;
        ifc.instr_ready = 1'b0;
        #3 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fill_rand();
        img[63] = 16'h1111;
        img[62] = 16'h2222;
        img[61] = 16'h3333;
        img[60] = 16'h4444;
        do_run(0, 4, 100, -1, -1, -1);
        do_run(0, 4, 100, 1, -1, -1);

        fill_rand();
        do_run(62, 4, 100, -1, -1, -1);
        do_run(62, 4, 70, 0, -1, -1);

        do_run(0, 0, 100, -1, -1, -1);
        do_run(5, 0, 80, -1, -1, -1);

        fill_rand();
        do_run(0, 5, 100, -1, 2, -1);
        do_run(0, 5, 100, -1, -1, 2);

        fill_rand();
        img[63] = 16'h0001;
        img[62] = 16'h0002;
        img[61] = 16'hF000;
        do_run(0, 8, 100, -1, -1, -1);

        for (int r = 0; r < 20; r++) begin
            fill_rand();
            len   = $urandom_range(64);
            n     = (len == 0) ? 64 : len;
            ab_at = ($urandom_range(3) == 0) ? $urandom_range(n - 1) : -1;
            rs_at = ($urandom_range(5) == 0) ? $urandom_range(n - 1) : -1;
            do_run($urandom_range(63), len, 60, $urandom_range(n - 1),
                   ab_at, rs_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
